// File: rtl/rs_alu_multi_if.sv
// Allocator/CDB/issue bundle for rs_alu_multi.
// Inputs are presented by the master (allocator, CDB, control); issue and status outputs return from the slave.
interface rs_alu_multi_if #(
  parameter int ENTRIES = 8,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6,
  parameter int REG_W   = 5,
  parameter int CDB_N   = 3,
  parameter int CNT_W   = $clog2(ENTRIES + 1)
);
  logic                      rdy;
  logic                      flush;
  logic                      en0, en1;
  logic [OP_W-1:0]           op0, op1;
  logic [31:0]               pc0, pc1;
  logic [TAG_W-1:0]          tagx0, tagy0, tagx1, tagy1;
  logic [DATA_W-1:0]         datax0, datay0, datax1, datay1;
  logic [TAG_W-1:0]          tagw0, tagw1;
  logic [REG_W-1:0]          addrw0, addrw1;
  logic [CDB_N-1:0]          cdb_valid;
  logic [CDB_N*TAG_W-1:0]    cdb_tag;
  logic [CDB_N*DATA_W-1:0]   cdb_data;
  logic                      full_out;
  logic [CNT_W-1:0]          count_out;
  logic                      iss_valid0, iss_valid1;
  logic [OP_W-1:0]           iss_op0, iss_op1;
  logic [31:0]               iss_pc0, iss_pc1;
  logic [DATA_W-1:0]         iss_datax0, iss_datax1, iss_datay0, iss_datay1;
  logic [TAG_W-1:0]          iss_tagw0, iss_tagw1;
  logic [REG_W-1:0]          iss_target0, iss_target1;

  modport master (
    output rdy, flush, en0, en1, op0, op1, pc0, pc1, tagx0, tagy0, tagx1, tagy1,
           datax0, datay0, datax1, datay1, tagw0, tagw1, addrw0, addrw1,
           cdb_valid, cdb_tag, cdb_data,
    input  full_out, count_out, iss_valid0, iss_valid1, iss_op0, iss_op1, iss_pc0, iss_pc1,
           iss_datax0, iss_datax1, iss_datay0, iss_datay1, iss_tagw0, iss_tagw1,
           iss_target0, iss_target1
  );

  modport slave (
    input  rdy, flush, en0, en1, op0, op1, pc0, pc1, tagx0, tagy0, tagx1, tagy1,
           datax0, datay0, datax1, datay1, tagw0, tagw1, addrw0, addrw1,
           cdb_valid, cdb_tag, cdb_data,
    output full_out, count_out, iss_valid0, iss_valid1, iss_op0, iss_op1, iss_pc0, iss_pc1,
           iss_datax0, iss_datax1, iss_datay0, iss_datay1, iss_tagw0, iss_tagw1,
           iss_target0, iss_target1
  );
endinterface

// File: rtl/rs_alu_multi.sv
// ALU reservation station: ENTRIES slots, dual dispatch with CDB bypass, CDB wakeup, dual registered issue.
// Ready dispatch issues 2 edges later; full_out asks the allocator to stop below 2 free slots; rdy=0 freezes all.
module rs_alu_multi #(
  parameter int ENTRIES = 8,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6,
  parameter int REG_W   = 5,
  parameter int CDB_N   = 3,
  parameter int CNT_W   = $clog2(ENTRIES + 1)
) (
  input logic          clk,
  input logic          rst,
  rs_alu_multi_if.slave io
);
  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [31:0]       pc;
    logic [TAG_W-1:0]  tagx;
    logic [DATA_W-1:0] datax;
    logic [TAG_W-1:0]  tagy;
    logic [DATA_W-1:0] datay;
    logic [TAG_W-1:0]  tagw;
    logic [REG_W-1:0]  addrw;
  } ent_t;

  ent_t             ent_q [ENTRIES];
  ent_t             ent_d [ENTRIES];
  logic [CNT_W-1:0] count_q, count_d;
  logic             found0, found1, fa_ok, fb_ok, do0, do1;
  logic [IDX_W-1:0] sel0, sel1, fa, fb, slot1;
  int               cnt_sum;

  // Lowest-indexed matching bus wins; tag 0 never matches.
  function automatic logic [TAG_W+DATA_W-1:0] snoop(
    input logic [TAG_W-1:0]        t,
    input logic [DATA_W-1:0]       d,
    input logic [CDB_N-1:0]        cv,
    input logic [CDB_N*TAG_W-1:0]  ct,
    input logic [CDB_N*DATA_W-1:0] cd
  );
    logic              hit;
    logic [TAG_W-1:0]  t_o;
    logic [DATA_W-1:0] d_o;
    hit = 1'b0;
    t_o = t;
    d_o = d;
    for (int i = 0; i < CDB_N; i++) begin
      if (!hit && t != '0 && cv[i] && ct[i*TAG_W +: TAG_W] == t) begin
        hit = 1'b1;
        t_o = '0;
        d_o = cd[i*DATA_W +: DATA_W];
      end
    end
    return {t_o, d_o};
  endfunction

  assign io.count_out = count_q;
  assign io.full_out  = (int'(count_q) > ENTRIES - 2);

  always_comb begin
    found0 = 1'b0; found1 = 1'b0; sel0 = '0; sel1 = '0;
    fa_ok  = 1'b0; fb_ok  = 1'b0; fa   = '0; fb   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ent_q[i].busy && ent_q[i].tagx == '0 && ent_q[i].tagy == '0) begin
        if (!found0) begin
          found0 = 1'b1; sel0 = IDX_W'(i);
        end else if (!found1) begin
          found1 = 1'b1; sel1 = IDX_W'(i);
        end
      end
      if (!ent_q[i].busy) begin
        if (!fa_ok) begin
          fa_ok = 1'b1; fa = IDX_W'(i);
        end else if (!fb_ok) begin
          fb_ok = 1'b1; fb = IDX_W'(i);
        end
      end
    end
    // Allocation sees pre-issue busy bits, so slots freed this edge are not reused until next cycle.
    do0   = io.rdy && !io.flush && !io.full_out && io.en0 && fa_ok;
    do1   = io.rdy && !io.flush && !io.full_out && io.en1 && (io.en0 ? fb_ok : fa_ok);
    slot1 = io.en0 ? fb : fa;

    for (int i = 0; i < ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy) begin
        {ent_d[i].tagx, ent_d[i].datax} =
          snoop(ent_q[i].tagx, ent_q[i].datax, io.cdb_valid, io.cdb_tag, io.cdb_data);
        {ent_d[i].tagy, ent_d[i].datay} =
          snoop(ent_q[i].tagy, ent_q[i].datay, io.cdb_valid, io.cdb_tag, io.cdb_data);
      end
      if ((found0 && sel0 == IDX_W'(i)) || (found1 && sel1 == IDX_W'(i)))
        ent_d[i].busy = 1'b0;
    end

    if (do0) begin
      ent_d[fa].busy  = 1'b1;
      ent_d[fa].op    = io.op0;
      ent_d[fa].pc    = io.pc0;
      {ent_d[fa].tagx, ent_d[fa].datax} = snoop(io.tagx0, io.datax0, io.cdb_valid, io.cdb_tag, io.cdb_data);
      {ent_d[fa].tagy, ent_d[fa].datay} = snoop(io.tagy0, io.datay0, io.cdb_valid, io.cdb_tag, io.cdb_data);
      ent_d[fa].tagw  = io.tagw0;
      ent_d[fa].addrw = io.addrw0;
    end
    if (do1) begin
      ent_d[slot1].busy  = 1'b1;
      ent_d[slot1].op    = io.op1;
      ent_d[slot1].pc    = io.pc1;
      {ent_d[slot1].tagx, ent_d[slot1].datax} = snoop(io.tagx1, io.datax1, io.cdb_valid, io.cdb_tag, io.cdb_data);
      {ent_d[slot1].tagy, ent_d[slot1].datay} = snoop(io.tagy1, io.datay1, io.cdb_valid, io.cdb_tag, io.cdb_data);
      ent_d[slot1].tagw  = io.tagw1;
      ent_d[slot1].addrw = io.addrw1;
    end

    cnt_sum = int'(count_q) + int'(do0) + int'(do1) - int'(found0) - int'(found1);
    if (cnt_sum < 0)       cnt_sum = 0;
    if (cnt_sum > ENTRIES) cnt_sum = ENTRIES;
    count_d = CNT_W'(cnt_sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
      count_q        <= '0;
      io.iss_valid0  <= 1'b0;     io.iss_valid1  <= 1'b0;
      io.iss_op0     <= '0;       io.iss_op1     <= '0;
      io.iss_pc0     <= '0;       io.iss_pc1     <= '0;
      io.iss_datax0  <= '0;       io.iss_datax1  <= '0;
      io.iss_datay0  <= '0;       io.iss_datay1  <= '0;
      io.iss_tagw0   <= '0;       io.iss_tagw1   <= '0;
      io.iss_target0 <= '0;       io.iss_target1 <= '0;
    end else if (io.rdy) begin
      if (io.flush) begin
        for (int i = 0; i < ENTRIES; i++) ent_q[i].busy <= 1'b0;
        count_q       <= '0;
        io.iss_valid0 <= 1'b0;
        io.iss_valid1 <= 1'b0;
      end else begin
        for (int i = 0; i < ENTRIES; i++) ent_q[i] <= ent_d[i];
        count_q       <= count_d;
        io.iss_valid0 <= found0;
        io.iss_valid1 <= found1;
        if (found0) begin
          io.iss_op0     <= ent_q[sel0].op;
          io.iss_pc0     <= ent_q[sel0].pc;
          io.iss_datax0  <= ent_q[sel0].datax;
          io.iss_datay0  <= ent_q[sel0].datay;
          io.iss_tagw0   <= ent_q[sel0].tagw;
          io.iss_target0 <= ent_q[sel0].addrw;
        end
        if (found1) begin
          io.iss_op1     <= ent_q[sel1].op;
          io.iss_pc1     <= ent_q[sel1].pc;
          io.iss_datax1  <= ent_q[sel1].datax;
          io.iss_datay1  <= ent_q[sel1].datay;
          io.iss_tagw1   <= ent_q[sel1].tagw;
          io.iss_target1 <= ent_q[sel1].addrw;
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_alu_multi.sv
// Directed bench for rs_alu_multi: stimulus pushes expected issues, a negedge monitor pops and compares.
module tb_rs_alu_multi;
  logic clk = 1'b0;
  logic rst;

  rs_alu_multi_if bus();
  rs_alu_multi dut (.clk(clk), .rst(rst), .io(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] dx;
    logic [31:0] dy;
    logic [3:0]  tw;
    logic [4:0]  tgt;
  } iss_t;

  typedef struct {
    iss_t f;
    int   at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  iss_t a0, a1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_iss(input int p, input iss_t act);
    exp_t e;
    n_chk++;
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      n_fail++;
      $display("FAIL iss%0d unexpected: got pc=%0h at cycle %0d, required no issue", p, act.pc, cyc);
    end else begin
      if (p == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      if (act !== e.f || cyc != e.at) begin
        n_fail++;
        $display("FAIL iss%0d: got op=%0h pc=%0h dx=%0h dy=%0h tw=%0h tgt=%0h cyc=%0d, required op=%0h pc=%0h dx=%0h dy=%0h tw=%0h tgt=%0h cyc=%0d",
                 p, act.op, act.pc, act.dx, act.dy, act.tw, act.tgt, cyc,
                 e.f.op, e.f.pc, e.f.dx, e.f.dy, e.f.tw, e.f.tgt, e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.iss_valid0) begin
        a0 = {bus.iss_op0, bus.iss_pc0, bus.iss_datax0, bus.iss_datay0, bus.iss_tagw0, bus.iss_target0};
        check_iss(0, a0);
      end
      if (bus.iss_valid1) begin
        a1 = {bus.iss_op1, bus.iss_pc1, bus.iss_datax1, bus.iss_datay1, bus.iss_tagw1, bus.iss_target1};
        check_iss(1, a1);
      end
    end
  end

  // op and destination register are derived from pc so every issue is self-identifying.
  task automatic push(input int p, input logic [31:0] pc, input logic [31:0] dx,
                      input logic [31:0] dy, input logic [3:0] tw, input int lat);
    exp_t e;
    e.f.op = pc[5:0]; e.f.pc = pc; e.f.dx = dx; e.f.dy = dy; e.f.tw = tw; e.f.tgt = pc[10:6];
    e.at = cyc + lat;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic dsp(input int p, input logic [31:0] pc, input logic [3:0] tx, input logic [31:0] dx,
                     input logic [3:0] ty, input logic [31:0] dy, input logic [3:0] tw);
    if (p == 0) begin
      bus.en0 = 1'b1; bus.op0 = pc[5:0]; bus.pc0 = pc; bus.tagx0 = tx; bus.datax0 = dx;
      bus.tagy0 = ty; bus.datay0 = dy; bus.tagw0 = tw; bus.addrw0 = pc[10:6];
    end else begin
      bus.en1 = 1'b1; bus.op1 = pc[5:0]; bus.pc1 = pc; bus.tagx1 = tx; bus.datax1 = dx;
      bus.tagy1 = ty; bus.datay1 = dy; bus.tagw1 = tw; bus.addrw1 = pc[10:6];
    end
  endtask

  task automatic blk(input int p, input logic [31:0] pc, input logic [3:0] ty);
    dsp(p, pc, 4'd0, pc, ty, 32'h0, pc[3:0]);
  endtask

  task automatic cdb(input int i, input logic [3:0] t, input logic [31:0] d);
    bus.cdb_valid[i]        = 1'b1;
    bus.cdb_tag[i*4 +: 4]   = t;
    bus.cdb_data[i*32 +: 32] = d;
  endtask

  task automatic idle();
    bus.en0 = 1'b0; bus.en1 = 1'b0; bus.cdb_valid = '0; bus.flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.rdy = 1'b1;
    idle();
    bus.cdb_tag = '0; bus.cdb_data = '0;
    dsp(0, 32'h0, 4'd0, 32'h0, 4'd0, 32'h0, 4'd0);
    dsp(1, 32'h0, 4'd0, 32'h0, 4'd0, 32'h0, 4'd0);
    idle();
    #2;
    chk("reset count", 64'(bus.count_out), 64'd0);
    chk("reset full", 64'(bus.full_out), 64'd0);
    chk("reset iss_valid", 64'({bus.iss_valid0, bus.iss_valid1}), 64'd0);
    chk("reset iss_pc0", 64'(bus.iss_pc0), 64'd0);
    #10 rst = 1'b0;
    tick();

    // Single ready op.
    dsp(0, 32'h0C1, 4'd0, 32'd5, 4'd0, 32'd7, 4'd3);
    push(0, 32'h0C1, 32'd5, 32'd7, 4'd3, 2);
    tick(); idle();
    chk("single count after dispatch", 64'(bus.count_out), 64'd1);
    tick();
    chk("single count after issue", 64'(bus.count_out), 64'd0);

    // Wakeup two cycles after dispatch.
    dsp(0, 32'h111, 4'd4, 32'h0, 4'd0, 32'h22, 4'd5);
    push(0, 32'h111, 32'h55, 32'h22, 4'd5, 4);
    tick(); idle();
    tick();
    cdb(2, 4'd4, 32'h55);
    tick(); idle();
    chk("wakeup count before issue", 64'(bus.count_out), 64'd1);
    tick(); tick();

    // Bypass in the dispatch cycle; buses 1 and 2 both match tagx, bus 1 wins.
    dsp(0, 32'h122, 4'd4, 32'h0, 4'd6, 32'h0, 4'd2);
    cdb(1, 4'd4, 32'h11); cdb(2, 4'd4, 32'h22); cdb(0, 4'd6, 32'h66);
    push(0, 32'h122, 32'h11, 32'h66, 4'd2, 2);
    tick(); idle();
    tick(); tick();

    // Four entries become ready together: 0/1 issue first, then 2/3.
    blk(0, 32'h200, 4'd5); blk(1, 32'h201, 4'd5);
    tick();
    blk(0, 32'h202, 4'd5); blk(1, 32'h203, 4'd5);
    tick(); idle();
    chk("dual fill count", 64'(bus.count_out), 64'd4);
    cdb(0, 4'd5, 32'hAB);
    push(0, 32'h200, 32'h200, 32'hAB, 4'h0, 2); push(1, 32'h201, 32'h201, 32'hAB, 4'h1, 2);
    push(0, 32'h202, 32'h202, 32'hAB, 4'h2, 3); push(1, 32'h203, 32'h203, 32'hAB, 4'h3, 3);
    tick(); idle();
    tick();
    chk("dual count after first issue", 64'(bus.count_out), 64'd2);
    tick();
    chk("dual count after second issue", 64'(bus.count_out), 64'd0);

    // Fill to ENTRIES-1, try dispatching while full, then drain.
    for (int k = 0; k < 3; k++) begin
      blk(0, 32'(32'h300 + 2*k), 4'd9); blk(1, 32'(32'h301 + 2*k), 4'd9);
      tick(); idle();
      chk("fill count", 64'(bus.count_out), 64'(2*k + 2));
      chk("fill full low", 64'(bus.full_out), 64'd0);
    end
    blk(0, 32'h306, 4'd9);
    tick(); idle();
    chk("count at ENTRIES-1", 64'(bus.count_out), 64'd7);
    chk("full at ENTRIES-1", 64'(bus.full_out), 64'd1);
    blk(0, 32'h3F0, 4'd0); blk(1, 32'h3F1, 4'd0);
    tick(); idle();
    chk("dispatch while full ignored", 64'(bus.count_out), 64'd7);
    cdb(0, 4'd9, 32'h99);
    for (int j = 0; j < 7; j++)
      push(j % 2, 32'(32'h300 + j), 32'(32'h300 + j), 32'h99, 4'(j), 2 + j/2);
    tick(); idle();
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("drain7 count", 64'(bus.count_out), 64'((j < 3) ? 5 - 2*j : 0));
      chk("drain7 full", 64'(bus.full_out), 64'd0);
    end

    // Dual-dispatch all ENTRIES, then drain at two per cycle.
    for (int k = 0; k < 4; k++) begin
      blk(0, 32'(32'h400 + 2*k), 4'd9); blk(1, 32'(32'h401 + 2*k), 4'd9);
      tick(); idle();
    end
    chk("count at ENTRIES", 64'(bus.count_out), 64'd8);
    chk("full at ENTRIES", 64'(bus.full_out), 64'd1);
    cdb(1, 4'd9, 32'h77);
    for (int j = 0; j < 8; j++)
      push(j % 2, 32'(32'h400 + j), 32'(32'h400 + j), 32'h77, 4'(j), 2 + j/2);
    tick(); idle();
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("drain8 count", 64'(bus.count_out), 64'(6 - 2*j));
      chk("drain8 full", 64'(bus.full_out), 64'd0);
    end

    // Asynchronous reset with 5 entries busy while both ports are issuing.
    blk(0, 32'h500, 4'd9); blk(1, 32'h501, 4'd9); tick();
    blk(0, 32'h502, 4'd9); blk(1, 32'h503, 4'd9); tick();
    blk(0, 32'h504, 4'd0); blk(1, 32'h505, 4'd0);
    push(0, 32'h504, 32'h504, 32'h0, 4'h4, 2); push(1, 32'h505, 32'h505, 32'h0, 4'h5, 2);
    tick(); idle();
    blk(0, 32'h506, 4'd9);
    tick(); idle();
    chk("pre-reset count", 64'(bus.count_out), 64'd5);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async reset count", 64'(bus.count_out), 64'd0);
    chk("async reset full", 64'(bus.full_out), 64'd0);
    chk("async reset iss_valid", 64'({bus.iss_valid0, bus.iss_valid1}), 64'd0);
    chk("async reset iss_datax0", 64'(bus.iss_datax0), 64'd0);
    #1 rst = 1'b0;
    tick();

    // Flush held off by rdy=0, then taking effect.
    blk(0, 32'h600, 4'd9); blk(1, 32'h601, 4'd9); tick();
    blk(0, 32'h602, 4'd9); blk(1, 32'h603, 4'd9); tick();
    blk(0, 32'h604, 4'd0); blk(1, 32'h605, 4'd0);
    tick(); idle();
    bus.rdy = 1'b0; bus.flush = 1'b1;
    tick(); tick();
    chk("rdy low count held", 64'(bus.count_out), 64'd6);
    chk("rdy low no issue", 64'({bus.iss_valid0, bus.iss_valid1}), 64'd0);
    bus.rdy = 1'b1;
    tick();
    chk("flush count", 64'(bus.count_out), 64'd0);
    chk("flush full", 64'(bus.full_out), 64'd0);
    bus.flush = 1'b0;
    tick();
    chk("flush no issue pulse", 64'({bus.iss_valid0, bus.iss_valid1}), 64'd0);
    cdb(0, 4'd9, 32'h5A);
    tick(); idle();
    tick();
    chk("no ghost entries after flush", 64'(bus.count_out), 64'd0);

    dsp(0, 32'h7C3, 4'd0, 32'h1234, 4'd0, 32'h5678, 4'd7);
    push(0, 32'h7C3, 32'h1234, 32'h5678, 4'd7, 2);
    tick(); idle();
    tick(); tick();
    chk("scoreboard port0 drained", 64'(q0.size()), 64'd0);
    chk("scoreboard port1 drained", 64'(q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rs_alu_multi.md
# rs_alu_multi

Parametrised successor to the two-entry ALU reservation station. It sits between the allocator and the ex_alu instances. It holds up to ENTRIES dispatched ALU micro-ops, wakes their operands from CDB_N result broadcasts, and issues up to two ready micro-ops per cycle to two ex_alu ports. It adds flush, occupancy/full reporting, and dispatch-time bypass, none of which the two-entry station has.

## Interface
- ENTRIES, 8: station depth; must be ≥ 2.
- TAG_W, 4: rename tag width; tag 0 means "operand value present".
- DATA_W, 32: operand/result width.
- OP_W, 6: micro-op (`sinst_t`) width.
- REG_W, 5: destination register address width.
- CDB_N, 3: number of result broadcast buses.
- CNT_W, $clog2(ENTRIES+1): occupancy counter width.

Ports:
- clk  in  1  clock. One clock domain; reset is asynchronous and active-high.
- rst  in  1  asynchronous active-high reset.
- rdy  in  1  global ready. When low, all state and outputs hold.
- flush  in  1  discard all entries and issue slots.
- en0, en1  in  1 each  dispatch valid, ports 0 and 1.
- op0/op1  in  OP_W  micro-op.
- pc0/pc1  in  32  instruction PC.
- tagx0/tagy0/tagx1/tagy1  in  TAG_W  source tags.
- datax0/datay0/datax1/datay1  in  DATA_W  source values, valid when the matching tag is 0.
- tagw0/tagw1  in  TAG_W  destination tag.
- addrw0/addrw1  in  REG_W  destination register.
- cdb_valid  in  CDB_N  broadcast valid, one bit per bus.
- cdb_tag  in  CDB_N*TAG_W  broadcast tags; bus i at [i*TAG_W +: TAG_W].
- cdb_data  in  CDB_N*DATA_W  broadcast data; same slicing.
- full_out  out  1  high when free entries < 2.
- count_out  out  CNT_W  number of occupied entries.
- iss_valid0/1  out  1  issue valid to ALU 0/1.
- iss_op0/1, iss_pc0/1, iss_datax0/1, iss_datay0/1, iss_tagw0/1, iss_target0/1  out  matching widths  issued micro-op fields.

## Operation
- Each entry holds: busy, op, pc, tagx, datax, tagy, datay, tagw, addrw.
- An entry is ready when busy=1, tagx=0 and tagy=0.
- Dispatch:
  - en0 takes the lowest-index free entry.
  - en1 takes the next free entry above it, or the lowest free entry if en0=0.
  - The allocator must not assert en0 or en1 while full_out=1. Dispatch while full is ignored and the station is not corrupted.
- Dispatch bypass: if an incoming source tag ≠ 0 matches any valid CDB tag in the same cycle, the entry stores the CDB data with tag 0.
- Wakeup: for every busy entry and every bus i with cdb_valid[i] and a matching nonzero tag, data is captured and the tag is cleared at the edge. If several buses match, the lowest i wins.
- Issue selection uses stored state only.
  - The lowest-index ready entry goes to port 0. The second lowest goes to port 1.
  - Each selected entry's busy bit clears at the same edge.
  - Outputs are registered. iss_validN is a one-cycle pulse; the ALUs always accept.
  - A port with no selected entry drives iss_validN=0. Its other fields hold their last value.
- Occupancy: count_out is updated as count + dispatched − issued. It never wraps; it is bounded by 0 and ENTRIES.
- Flush: at the edge, all busy bits, iss_valid0/1 and count_out clear. Dispatch and CDB in the same cycle are dropped. Flush has priority over everything except rst.
- rdy=0: no dispatch, wakeup, issue or flush takes effect. iss_valid holds its value. The allocator and CDB must hold their inputs while rdy=0.

## Timing
- Reset (asynchronous): all busy bits 0, count_out=0, full_out=0, iss_valid0/1=0, all iss_* fields 0.
- Dispatch with both tags 0 at edge N → iss_valid high after edge N+1 (latency 2 edges).
- CDB wakeup at edge N → issue at edge N+1 at the earliest.
- Dispatch and the matching CDB in the same cycle: bypass captured at edge N, issue at edge N+1.
- An entry freed by issue at edge N is allocatable in the cycle after edge N. Free slots are not forwarded within the same cycle.
- full_out and count_out are derived from registered state, so they are valid from the cycle after each edge.
- Dual dispatch and dual issue in the same cycle are supported. count_out changes by +2, −2 or any value in between.

## Test plan
- Reset mid-operation: with 5 entries busy, assert rst asynchronously. Required: count_out=0, full_out=0 and iss_valid0/1=0 immediately, before the next edge.
- Single ready op: dispatch en0 with op=ADD, datax=5, datay=7, tagw=3 at edge 0. Required: iss_valid0=1 with datax=5, datay=7, tagw=3 after edge 1; count_out returns 1→0.
- Wakeup and bypass:
  - Dispatch tagx=4 at edge 0, then cdb_valid[2]=1 with tag 4 and data 0x55 at edge 2. Required: issue after edge 3 with datax=0x55.
  - Same dispatch with the CDB in the dispatch cycle. Required: issue after edge 1.
- Dual issue and ordering: fill entries 0–3 ready. Required:
  - Entries 0 and 1 issue on ports 0/1 after the first edge.
  - Entries 2 and 3 issue after the next edge.
- Full/back-pressure: dual-dispatch ENTRIES blocked ops (tag 9). Required:
  - full_out=1 at count ENTRIES−1, and count_out=ENTRIES.
  - Broadcasting tag 9 drains all entries at 2 per cycle, and full_out drops once at least 2 entries are free.
- Flush and rdy: with 6 entries busy, hold rdy=0 with flush=1. Required: no change. Raise rdy. Required: count_out=0 and no iss_valid pulse on the following cycle.
